// File: rtl/seg_pkg.sv
// Shared types and segment constants for the seven-segment receive path.
// Segment order is bit 6 = a ... bit 0 = g, active-high.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_BLANK = 7'b0000000;

    typedef enum logic {EMPTY, PENDING} out_state_t;

endpackage

// File: rtl/seg_lookup.sv
// Combinational segment-pattern to digit decoder.
// Hex letters A..F decode only when SEG_DECODER_HEX_EN is defined.
module seg_lookup
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       is_digit,
    output logic       is_blank
);

    always_comb begin
        digit    = 4'd0;
        is_digit = 1'b1;
        is_blank = 1'b0;
        unique case (seg)
            SEG_0: digit = 4'd0;
            SEG_1: digit = 4'd1;
            SEG_2: digit = 4'd2;
            SEG_3: digit = 4'd3;
            SEG_4: digit = 4'd4;
            SEG_5: digit = 4'd5;
            SEG_6: digit = 4'd6;
            SEG_7: digit = 4'd7;
            SEG_8: digit = 4'd8;
            SEG_9: digit = 4'd9;
`ifdef SEG_DECODER_HEX_EN
            SEG_A: digit = 4'd10;
            SEG_B: digit = 4'd11;
            SEG_C: digit = 4'd12;
            SEG_D: digit = 4'd13;
            SEG_E: digit = 4'd14;
            SEG_F: digit = 4'd15;
`endif
            SEG_BLANK: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default: is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_decoder.sv
// Debounces a seven-segment bus and offers decoded digits on valid/ready.
// Optional hex letters via SEG_DECODER_HEX_EN (see seg_lookup).
module seg_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    output logic [3:0] digit_out,
    output logic       digit_valid,
    input  logic       digit_ready,
    output logic       blank,
    output logic       err_invalid,
    output logic       overrun
);

    localparam int unsigned RunW = $clog2(STABLE_CYCLES + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(STABLE_CYCLES);
    localparam logic [RunW-1:0] RunOne = RunW'(1);

    seg_t            cand_q, cand_d;
    logic [RunW-1:0] run_q, run_d;
    logic            commit;
    logic [3:0]      lk_digit;
    logic            lk_is_digit, lk_is_blank;
    out_state_t      state_q;

    always_comb begin
        cand_d = cand_q;
        run_d  = run_q;
        if (seg_in == cand_q) begin
            if (run_q != RunMax) run_d = run_q + RunOne;
        end else begin
            cand_d = seg_in;
            run_d  = RunOne;
        end
    end

    // A new pattern always starts "from below", even when the old run was saturated
    // (matters for STABLE_CYCLES == 1).
    assign commit = (run_d == RunMax) && ((seg_in != cand_q) || (run_q != RunMax));

    seg_lookup u_lookup (
        .seg      (cand_d),
        .digit    (lk_digit),
        .is_digit (lk_is_digit),
        .is_blank (lk_is_blank)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q <= SEG_BLANK;
            run_q  <= '0;
        end else begin
            cand_q <= cand_d;
            run_q  <= run_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            digit_out   <= 4'd0;
            blank       <= 1'b0;
            err_invalid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            err_invalid <= commit && !lk_is_digit && !lk_is_blank;
            if (state_q == PENDING && digit_ready) state_q <= EMPTY;
            // A same-cycle digit commit wins over the transfer and keeps PENDING.
            if (commit && lk_is_digit) begin
                state_q   <= PENDING;
                digit_out <= lk_digit;
                blank     <= 1'b0;
                if (state_q == PENDING && !digit_ready) overrun <= 1'b1;
            end
            if (commit && lk_is_blank) blank <= 1'b1;
        end
    end

    assign digit_valid = (state_q == PENDING);

endmodule

// File: doc/seg_decoder.md
# seg_decoder

Receive-side counterpart of the seven-segment driver: samples a 7-bit segment pattern bus (a..g, active-high), waits until the pattern has been stable for a programmable number of cycles, and decodes it back into a 4-bit digit. Decoded digits are offered on a valid/ready handshake. Used to read back or loop-test display outputs and to accept segment-encoded input from external boards.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pattern is committed; legal range ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `seg_in` in 7: raw pattern; bit 6 = a … bit 0 = g.
- `digit_out` out 4: last committed decoded digit.
- `digit_valid` out 1: `digit_out` holds an unaccepted digit.
- `digit_ready` in 1: consumer accepts; a transfer occurs on `digit_valid && digit_ready`.
- `blank` out 1: last committed pattern was all-zero.
- `err_invalid` out 1: one-cycle pulse; a non-decodable pattern was committed.
- `overrun` out 1: sticky; a pending digit was overwritten. Cleared only by `rst`.

## Operation
- Pattern tracker: registers `cand` (7 b) and `run` (saturating at `STABLE_CYCLES`). Each edge: if `seg_in == cand`, `run <= min(run+1, STABLE_CYCLES)`; else `cand <= seg_in`, `run <= 1`.
- A commit occurs at the edge where `run` becomes `STABLE_CYCLES` from below. There is exactly one commit per stable run. A→B→A produces three commits.
- Decode table, 0–9: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
- Commit of a digit pattern: `digit_out <= value`, `digit_valid <= 1`, `blank <= 0`.
- Commit of 0000000: `blank <= 1`. `digit_valid` and `digit_out` are unchanged.
- Commit of any other pattern: `err_invalid` pulses. `blank`, `digit_valid` and `digit_out` are unchanged.
- Output FSM has two states:
  - EMPTY → PENDING on a digit commit.
  - PENDING → EMPTY on transfer with no same-cycle digit commit.
  - PENDING stays PENDING on a digit commit with `digit_ready=0`. The new digit overwrites the old one and `overrun <= 1`.
  - PENDING stays PENDING on a digit commit with `digit_ready=1`. The old digit transfers, the new one loads, and `overrun` is not set.
- `digit_ready` in EMPTY is ignored.

## Timing
- Reset values: `cand=0`, `run=0`, FSM=EMPTY. All outputs are 0.
- After reset with `seg_in=0` held, a blank commit occurs after `STABLE_CYCLES` edges.
- Latency: if `seg_in` first holds a new value at sampling edge k, the commit happens at edge k+STABLE_CYCLES−1. Outputs are registered and visible immediately after that edge.
- With `STABLE_CYCLES=1`, every change commits on its first sample edge.
- `err_invalid` is high for exactly the one cycle following the commit edge.
- `rst` mid-run discards `cand`/`run` and any pending digit. It does not cause a commit.
- There is no combinational path from any input to any output.

## Configuration
- Macro: `SEG_DECODER_HEX_EN`.
- When defined, six more patterns decode:
  - 1110111 = A (10)
  - 0011111 = b (11)
  - 1001110 = C (12)
  - 0111101 = d (13)
  - 1001111 = E (14)
  - 1000111 = F (15)
- When undefined, these six patterns are invalid and pulse `err_invalid`. `digit_out` is then always 0–9.

## Structure
- Package `seg_pkg`:
  - `seg_t` typedef (logic [6:0]).
  - Constants `SEG_0`…`SEG_9`, `SEG_A`…`SEG_F`, `SEG_BLANK`.
  - Output-state enum (`EMPTY`, `PENDING`).
- Sub-module `seg_lookup`: purely combinational. Maps `seg_t` to digit + `is_digit` + `is_blank`. Honours `SEG_DECODER_HEX_EN`.
- The top holds the tracker, commit logic, output FSM and flags.

## Test plan
- `STABLE_CYCLES=4`, reset, `seg_in=0110000` held, `digit_ready=0`. Expect `digit_valid=1` and `digit_out=1` after the 4th sample edge. Both hold until `digit_ready=1`, then `digit_valid=0` next cycle.
- Glitch: 1111001 for 3 cycles then 1111111 held. Expect no commit during the first 3 cycles. Expect `digit_out=8` after the 4th cycle of 1111111 and no `err_invalid`.
- Overrun: commit 2 (1101101), not accepted, then 1011011 stable for 4 cycles. Expect `digit_out=5`, `digit_valid=1`, `overrun=1`. After `rst`, all outputs are 0.
- Invalid: 0000001 stable for 4 cycles with digit 3 pending. Expect `err_invalid` high for exactly 1 cycle, `digit_out=3` and `digit_valid=1` unchanged. Then 0000000 stable: expect `blank=1` and no valid change.
- Simultaneous: digit 3 pending, `digit_ready=1` exactly in the commit cycle of 7 (1110000). Expect `digit_valid` to stay 1, `digit_out=7`, `overrun=0`.
- Hex: 1110111 stable. With `SEG_DECODER_HEX_EN` expect `digit_out=10` and valid. Without it expect an `err_invalid` pulse and no valid.
